// File: rtl/cmd_initiator_fsm.sv
// Initiator for the cmd/rsp valid-ready handshake. It issues num_cmds command+response pairs per start pulse.
// Optional per-phase wait timeout is enabled by defining CMD_INITIATOR_TIMEOUT_EN.
module cmd_initiator_fsm #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cmds,
    output logic             cmd_vld,
    input  logic             cmd_rdy,
    input  logic             rsp_vld,
    output logic             rsp_rdy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cmd_count
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_q, num_nxt, count_nxt, count_inc;
    logic             cmd_vld_nxt, rsp_rdy_nxt, busy_nxt, done_nxt, err_nxt;
    logic             cmd_hs, rsp_hs, timeout_hit;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("cmd_initiator_fsm: TIMEOUT must be in 1..65535");
    end

    assign cmd_hs    = cmd_vld & cmd_rdy;
    assign rsp_hs    = rsp_rdy & rsp_vld;
    assign count_inc = cmd_count + CNT_W'(1);

`ifdef CMD_INITIATOR_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // busy is exactly "in CMD or RSP", so the count restarts on every phase entry via the handshake or IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (busy && !cmd_hs && !rsp_hs)
            wait_cnt <= wait_cnt + 16'd1;
        else
            wait_cnt <= '0;
    end

    assign timeout_hit = busy && !cmd_hs && !rsp_hs && (wait_cnt == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            num_q     <= '0;
            cmd_count <= '0;
            cmd_vld   <= 1'b0;
            rsp_rdy   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            num_q     <= num_nxt;
            cmd_count <= count_nxt;
            cmd_vld   <= cmd_vld_nxt;
            rsp_rdy   <= rsp_rdy_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        num_nxt     = num_q;
        count_nxt   = cmd_count;
        cmd_vld_nxt = cmd_vld;
        rsp_rdy_nxt = rsp_rdy;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;

        unique case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                    if (num_cmds != '0) begin
                        num_nxt     = num_cmds;
                        state_nxt   = S_CMD;
                        cmd_vld_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (cmd_hs) begin
                    state_nxt   = S_RSP;
                    cmd_vld_nxt = 1'b0;
                    rsp_rdy_nxt = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt   = S_ERR;
                    cmd_vld_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_hs) begin
                    rsp_rdy_nxt = 1'b0;
                    count_nxt   = count_inc;
                    if (count_inc == num_q) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_CMD;
                        cmd_vld_nxt = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nxt   = S_ERR;
                    rsp_rdy_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_initiator_fsm.sv
// Directed bench for cmd_initiator_fsm: a configurable-latency responder plus per-cycle traces of the outputs.
module tb_cmd_initiator_fsm;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_cmds;
    logic             cmd_vld, cmd_rdy, rsp_vld, rsp_rdy;
    logic             busy, done, err;
    logic [CNT_W-1:0] cmd_count;

    cmd_initiator_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cmds(num_cmds),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle k of a trace is the interval after the k-th edge following the start request.
    int          cyc;
    logic [31:0] cmd_mask, rsp_mask, done_mask, busy_mask, err_mask;
    int          n_done, overlap;
    int          cmd_dly, rsp_dly, cmd_hold, rsp_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_trace();
        cyc = 0;
        cmd_mask = '0; rsp_mask = '0; done_mask = '0; busy_mask = '0; err_mask = '0;
        n_done = 0; cmd_hold = 0; rsp_hold = 0;
    endtask

    // Advance one cycle, record outputs mid-cycle, then play the responder.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc < 32) begin
            cmd_mask[cyc]  = cmd_vld;
            rsp_mask[cyc]  = rsp_rdy;
            done_mask[cyc] = done;
            busy_mask[cyc] = busy;
            err_mask[cyc]  = err;
        end
        if (done) n_done++;
        if (cmd_vld && rsp_rdy) overlap++;
        cmd_hold = cmd_vld ? cmd_hold + 1 : 0;
        rsp_hold = rsp_rdy ? rsp_hold + 1 : 0;
        cmd_rdy  = cmd_vld && (cmd_hold > cmd_dly);
        rsp_vld  = rsp_rdy && (rsp_hold > rsp_dly);
        start    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic kick(input int n);
        clear_trace();
        num_cmds = CNT_W'(n);
        start    = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_cmds = '0; cmd_rdy = 1'b0; rsp_vld = 1'b0;
        cmd_dly = 0; rsp_dly = 0; overlap = 0;
        clear_trace();
        repeat (2) @(negedge clk);
        check("reset_outputs", {cmd_vld, rsp_rdy, busy, done, err, 19'd0, cmd_count}, 32'h0);
        rst = 1'b0;

        // Zero-wait responder, three commands.
        kick(3);
        run(10);
        check("zw_cmd_cycles",  cmd_mask,  32'h0000_002A);
        check("zw_rsp_cycles",  rsp_mask,  32'h0000_0054);
        check("zw_done_cycle",  done_mask, 32'h0000_0080);
        check("zw_busy_cycles", busy_mask, 32'h0000_007E);
        check("zw_count",       cmd_count, 32'd3);
        check("zw_err",         err,       32'd0);

        // Slow responder: cmd_rdy four cycles late, rsp_vld two cycles late.
        cmd_dly = 4; rsp_dly = 2;
        kick(1);
        run(12);
        check("slow_cmd_cycles", cmd_mask,  32'h0000_003E);
        check("slow_rsp_cycles", rsp_mask,  32'h0000_01C0);
        check("slow_done_cycle", done_mask, 32'h0000_0200);
        check("slow_count",      cmd_count, 32'd1);
        cmd_dly = 0; rsp_dly = 0;

        // Empty burst.
        kick(0);
        run(4);
        check("zero_done_cycle", done_mask, 32'h0000_0002);
        check("zero_cmd_cycles", cmd_mask,  32'h0);
        check("zero_count",      cmd_count, 32'd0);

        // Start while busy is ignored.
        kick(2);
        step();
        start = 1'b1; num_cmds = CNT_W'(5);
        run(10);
        check("busy_start_cmds",  $countones(cmd_mask), 32'd2);
        check("busy_start_dones", n_done,               32'd1);
        check("busy_start_done",  done_mask,            32'h0000_0020);
        check("busy_start_count", cmd_count,            32'd2);

        // Reset in the RSP phase of a four-command burst.
        kick(4);
        run(4);
        check("pre_rst_rsp_rdy", rsp_rdy, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {cmd_vld, rsp_rdy, busy, done, 20'd0, cmd_count}, 32'h0);
        run(2);
        rst = 1'b0;
        clear_trace();
        run(4);
        check("post_rst_no_done", n_done,   32'd0);
        check("post_rst_idle",    cmd_mask, 32'h0);
        kick(2);
        run(8);
        check("post_rst_done",  done_mask, 32'h0000_0020);
        check("post_rst_count", cmd_count, 32'd2);

`ifdef CMD_INITIATOR_TIMEOUT_EN
        // Dead responder: timeout after TIMEOUT cycles in CMD, then recovery.
        cmd_dly = 1000;
        kick(2);
        run(20);
        check("to_cmd_cycles", cmd_mask, 32'h0001_FFFE);
        check("to_err_cycles", err_mask, 32'h001E_0000);
        check("to_no_done",    n_done,   32'd0);
        check("to_idle_outs",  {cmd_vld, rsp_rdy, busy}, 32'd0);
        check("to_count_hold", cmd_count, 32'd0);
        cmd_dly = 0;
        kick(1);
        run(5);
        check("to_recover_err",   err_mask,  32'h0);
        check("to_recover_done",  n_done,    32'd1);
        check("to_recover_count", cmd_count, 32'd1);
`endif

        check("no_overlap", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
